// File: rtl/switch_debouncer.sv
// switch_debouncer: per-channel synchroniser + debounce counter with rise/fall pulses.
// Define SW_GLITCH_COUNT_EN to add the saturating 8-bit glitch_count output.
module switch_debouncer #(
    parameter int NUM_SW          = 2,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_SW-1:0] sw_raw,
    output logic [NUM_SW-1:0] switches,
    output logic [NUM_SW-1:0] sw_rise,
    output logic [NUM_SW-1:0] sw_fall,
`ifdef SW_GLITCH_COUNT_EN
    output logic [7:0]        glitch_count,
`endif
    output logic              sw_changed
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    logic [SYNC_STAGES-1:0][NUM_SW-1:0] r_sync;
    logic [CW-1:0]                      r_cnt [NUM_SW];
    logic [NUM_SW-1:0]                  w_sync;
    logic [NUM_SW-1:0]                  w_diff;
    logic [NUM_SW-1:0]                  w_acc;
    assign w_sync = r_sync[SYNC_STAGES-1];
    assign w_diff = w_sync ^ switches;
    for (genvar i = 0; i < NUM_SW; i++) begin : g_acc
        assign w_acc[i] = w_diff[i] && (r_cnt[i] == LAST);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync     <= '0;
            for (int k = 0; k < NUM_SW; k++) r_cnt[k] <= '0;
            switches   <= '0;
            sw_rise    <= '0;
            sw_fall    <= '0;
            sw_changed <= 1'b0;
        end else begin
            r_sync     <= {r_sync[SYNC_STAGES-2:0], sw_raw};
            for (int k = 0; k < NUM_SW; k++) r_cnt[k] <= (w_diff[k] && !w_acc[k]) ? r_cnt[k] + CW'(1) : '0;
            switches   <= switches ^ w_acc;
            sw_rise    <= w_acc & ~switches;
            sw_fall    <= w_acc & switches;
            sw_changed <= |w_acc;
        end
    end
`ifdef SW_GLITCH_COUNT_EN
    logic [31:0] w_rej;
    logic [31:0] w_gsum;
    always_comb begin
        w_rej = '0;
        for (int k = 0; k < NUM_SW; k++) w_rej = w_rej + 32'(!w_diff[k] && (r_cnt[k] != '0));
        w_gsum = 32'(glitch_count) + w_rej;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) glitch_count <= '0;
        else     glitch_count <= (w_gsum > 32'd255) ? 8'd255 : w_gsum[7:0];
    end
`endif
endmodule

// File: tb/tb_switch_debouncer.sv
// tb_switch_debouncer: two instances (DEBOUNCE_CYCLES 4 and 1) checked against a sample-history model.
module tb_switch_debouncer;
    localparam int SS = 2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] raw4 = 2'b00, raw1 = 2'b00;
    logic [1:0] sw4, rs4, fl4, sw1, rs1, fl1;
    logic ch4, ch1;
`ifdef SW_GLITCH_COUNT_EN
    logic [7:0] gl4, gl1;
`endif
    logic [1:0] h4[$], h1[$];
    logic [1:0] e_sw4, e_rs4, e_fl4, e_sw1, e_rs1, e_fl1;
    logic e_ch4, e_ch1;
    int e_gl4, e_gl1;
    int checks = 0, fails = 0;

    always #5 clk = ~clk;

    switch_debouncer #(.NUM_SW(2), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst), .sw_raw(raw4), .switches(sw4), .sw_rise(rs4), .sw_fall(fl4),
`ifdef SW_GLITCH_COUNT_EN
        .glitch_count(gl4),
`endif
        .sw_changed(ch4));

    switch_debouncer #(.NUM_SW(2), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .sw_raw(raw1), .switches(sw1), .sw_rise(rs1), .sw_fall(fl1),
`ifdef SW_GLITCH_COUNT_EN
        .glitch_count(gl1),
`endif
        .sw_changed(ch1));

    function automatic void model_reset();
        h4 = {};
        h1 = {};
        for (int k = 0; k < 8; k++) begin
            h4.push_back(2'b00);
            h1.push_back(2'b00);
        end
        {e_sw4, e_rs4, e_fl4, e_ch4, e_sw1, e_rs1, e_fl1, e_ch1} = '0;
        e_gl4 = 0;
        e_gl1 = 0;
    endfunction

    // A level is accepted once the last d synchronised samples all disagree with it.
    function automatic void step(input logic [1:0] h[$], input int d, inout logic [1:0] lv,
                                 output logic [1:0] r, output logic [1:0] f, output logic c, inout int g);
        int n = h.size();
        r = 2'b00;
        f = 2'b00;
        for (int ch = 0; ch < 2; ch++) begin
            int agree = 0;
            for (int k = 0; k < d; k++) if (h[n-1-SS-k][ch] == lv[ch]) agree++;
            if (agree == 0) begin
                r[ch] = ~lv[ch];
                f[ch] = lv[ch];
            end else if (h[n-1-SS][ch] == lv[ch] && h[n-2-SS][ch] != lv[ch] && g < 255) g++;
        end
        lv = lv ^ (r | f);
        c = |(r | f);
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else begin
            h4.push_back(raw4);
            h1.push_back(raw1);
            if (h4.size() > 16) begin
                void'(h4.pop_front());
                void'(h1.pop_front());
            end
            step(h4, 4, e_sw4, e_rs4, e_fl4, e_ch4, e_gl4);
            step(h1, 1, e_sw1, e_rs1, e_fl1, e_ch1, e_gl1);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        int hit = -1, pulses = 0;
        rst = 1'b1;
        raw4 = 2'b11;
        raw1 = 2'b00;
        model_reset();
        repeat (3) tick();
        checks++;
        if ({sw4, rs4, fl4, ch4} !== 7'b0) begin
            fails++; $display("FAIL reset_hold got %b want 0000000", {sw4, rs4, fl4, ch4});
        end
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            checks++;
            if ({sw4, rs4, fl4, ch4, sw1, rs1, fl1, ch1} !== {e_sw4, e_rs4, e_fl4, e_ch4, e_sw1, e_rs1, e_fl1, e_ch1}) begin
                fails++; $display("FAIL reset_model k=%0d got %b want %b", k, {sw4, rs4, fl4, ch4, sw1, rs1, fl1, ch1}, {e_sw4, e_rs4, e_fl4, e_ch4, e_sw1, e_rs1, e_fl1, e_ch1});
            end
            if (sw4 === 2'b11 && hit < 0) begin
                hit = k;
                checks++;
                if (rs4 !== 2'b11 || ch4 !== 1'b1) begin
                    fails++; $display("FAIL reset_rise_pulse got rise=%b chg=%b want 11/1", rs4, ch4);
                end
            end
            pulses += int'(ch4);
        end
        checks++;
        if (hit !== 5) begin fails++; $display("FAIL reset_latency got %0d want 5", hit); end
        checks++;
        if (pulses !== 1) begin fails++; $display("FAIL reset_changed_count got %0d want 1", pulses); end
    endtask

    task automatic test_clean_rise();
        int hit = -1, rises = 0, falls = 0;
        raw4 = 2'b00;
        repeat (10) tick();
        checks++;
        if (sw4 !== 2'b00) begin fails++; $display("FAIL clean_settle_low got %b want 00", sw4); end
        raw4 = 2'b01;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if ({sw4, rs4, fl4, ch4, sw1, rs1, fl1, ch1} !== {e_sw4, e_rs4, e_fl4, e_ch4, e_sw1, e_rs1, e_fl1, e_ch1}) begin
                fails++; $display("FAIL clean_model k=%0d got %b want %b", k, {sw4, rs4, fl4, ch4, sw1, rs1, fl1, ch1}, {e_sw4, e_rs4, e_fl4, e_ch4, e_sw1, e_rs1, e_fl1, e_ch1});
            end
            if (sw4[0] === 1'b1 && hit < 0) hit = k;
            rises += int'(rs4[0]);
            falls += int'(|fl4);
        end
        checks++;
        if (hit !== 5) begin fails++; $display("FAIL clean_latency got %0d want 5", hit); end
        checks++;
        if (rises !== 1 || falls !== 0) begin
            fails++; $display("FAIL clean_pulses got rise=%0d fall=%0d want 1/0", rises, falls);
        end
    endtask

    task automatic test_bounce();
        logic pat[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        int hit = -1, rises = 0;
        for (int r = 0; r < 5; r++) begin
            for (int p = 0; p < 7; p++) begin
                raw4[1] = pat[p];
                tick();
                checks++;
                if ({sw4, rs4, fl4, ch4} !== {e_sw4, e_rs4, e_fl4, e_ch4} || sw4[1] !== 1'b0) begin
                    fails++; $display("FAIL bounce_reject r=%0d p=%0d got %b want %b", r, p, {sw4, rs4, fl4, ch4}, {e_sw4, e_rs4, e_fl4, e_ch4});
                end
            end
        end
        raw4[1] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if ({sw4, rs4, fl4, ch4} !== {e_sw4, e_rs4, e_fl4, e_ch4}) begin
                fails++; $display("FAIL bounce_model k=%0d got %b want %b", k, {sw4, rs4, fl4, ch4}, {e_sw4, e_rs4, e_fl4, e_ch4});
            end
            if (sw4[1] === 1'b1 && hit < 0) hit = k;
            rises += int'(rs4[1]);
        end
        checks++;
        if (hit !== 5 || rises !== 1) begin
            fails++; $display("FAIL bounce_accept got edge=%0d rises=%0d want 5/1", hit, rises);
        end
`ifdef SW_GLITCH_COUNT_EN
        checks++;
        if (gl4 !== 8'd10 || gl4 !== 8'(e_gl4)) begin
            fails++; $display("FAIL bounce_glitch_count got %0d want 10 (model %0d)", gl4, e_gl4);
        end
`endif
    endtask

    task automatic test_cross();
        int both = -1, chg = 0;
        raw4 = 2'b01;
        repeat (10) tick();
        checks++;
        if (sw4 !== 2'b01) begin fails++; $display("FAIL cross_setup got %b want 01", sw4); end
        raw4 = 2'b10;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if ({sw4, rs4, fl4, ch4} !== {e_sw4, e_rs4, e_fl4, e_ch4}) begin
                fails++; $display("FAIL cross_model k=%0d got %b want %b", k, {sw4, rs4, fl4, ch4}, {e_sw4, e_rs4, e_fl4, e_ch4});
            end
            if (rs4 === 2'b10 && fl4 === 2'b01) both = k;
            chg += int'(ch4);
        end
        checks++;
        if (both !== 5 || chg !== 1) begin
            fails++; $display("FAIL cross_same_cycle got edge=%0d changed=%0d want 5/1", both, chg);
        end
    endtask

    task automatic test_reset_mid();
        int hit = -1;
        raw4 = 2'b11;
        repeat (4) tick();
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if ({sw4, rs4, fl4, ch4} !== 7'b0) begin
            fails++; $display("FAIL midreset_clear got %b want 0000000", {sw4, rs4, fl4, ch4});
        end
        repeat (2) tick();
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if ({sw4, rs4, fl4, ch4} !== {e_sw4, e_rs4, e_fl4, e_ch4}) begin
                fails++; $display("FAIL midreset_model k=%0d got %b want %b", k, {sw4, rs4, fl4, ch4}, {e_sw4, e_rs4, e_fl4, e_ch4});
            end
            if (sw4 === 2'b11 && hit < 0) begin
                hit = k;
                checks++;
                if (rs4 !== 2'b11) begin fails++; $display("FAIL midreset_rise got %b want 11", rs4); end
            end
        end
        checks++;
        if (hit !== 5) begin fails++; $display("FAIL midreset_latency got %0d want 5", hit); end
    endtask

    task automatic test_db1();
        logic a[$];
        int pulses = 0;
        logic exp;
        raw1 = 2'b00;
        repeat (4) tick();
        for (int k = 0; k < 28; k++) begin
            raw1[0] = (k < 24) ? ~1'((k / 3) % 2) : 1'b0;
            a.push_back(raw1[0]);
            tick();
            exp = (k >= 2) ? a[k-2] : 1'b0;
            checks++;
            if (sw1[0] !== exp || {sw1, rs1, fl1, ch1} !== {e_sw1, e_rs1, e_fl1, e_ch1}) begin
                fails++; $display("FAIL db1_follow k=%0d got sw=%b want %b (full %b vs %b)", k, sw1[0], exp, {sw1, rs1, fl1, ch1}, {e_sw1, e_rs1, e_fl1, e_ch1});
            end
            pulses += int'(rs1[0]) + int'(fl1[0]);
        end
        checks++;
        if (pulses !== 8) begin fails++; $display("FAIL db1_pulses got %0d want 8", pulses); end
    endtask

    task automatic test_random();
        int hold4 = 0, hold1 = 0;
        for (int k = 0; k < 400; k++) begin
            if (hold4 == 0) begin raw4 = 2'($urandom); hold4 = $urandom_range(1, 7); end
            if (hold1 == 0) begin raw1 = 2'($urandom); hold1 = $urandom_range(1, 4); end
            hold4--;
            hold1--;
            rst = ($urandom_range(0, 79) == 0);
            if (rst) model_reset();
            tick();
            rst = 1'b0;
            checks++;
            if ({sw4, rs4, fl4, ch4, sw1, rs1, fl1, ch1} !== {e_sw4, e_rs4, e_fl4, e_ch4, e_sw1, e_rs1, e_fl1, e_ch1}) begin
                fails++; $display("FAIL random_model k=%0d got %b want %b", k, {sw4, rs4, fl4, ch4, sw1, rs1, fl1, ch1}, {e_sw4, e_rs4, e_fl4, e_ch4, e_sw1, e_rs1, e_fl1, e_ch1});
            end
            checks++;
            if ((rs4 & fl4) !== 2'b00 || (rs1 & fl1) !== 2'b00) begin
                fails++; $display("FAIL random_rise_fall_overlap k=%0d got %b/%b want 00", k, rs4 & fl4, rs1 & fl1);
            end
`ifdef SW_GLITCH_COUNT_EN
            checks++;
            if (gl4 !== 8'(e_gl4) || gl1 !== 8'(e_gl1)) begin
                fails++; $display("FAIL random_glitch k=%0d got %0d/%0d want %0d/%0d", k, gl4, gl1, e_gl4, e_gl1);
            end
`endif
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_clean_rise();
        test_bounce();
        test_cross();
        test_reset_mid();
        test_db1();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
